// File: rtl/command_tag_credit_control_if.sv
// Command/response handshake bundle between the AFU command arbiter, the PSL
// response stream and the tag/credit controller.
interface command_tag_credit_control_if #(
  parameter int TAG_WIDTH = 8
);
  logic                 cmd_req;
  logic                 cmd_grant;
  logic [TAG_WIDTH-1:0] cmd_tag;
  logic                 resp_valid;
  logic [TAG_WIDTH-1:0] resp_tag;
  logic [8:0]           resp_credits;

  modport master (
    output cmd_req, resp_valid, resp_tag, resp_credits,
    input  cmd_grant, cmd_tag
  );

  modport slave (
    input  cmd_req, resp_valid, resp_tag, resp_credits,
    output cmd_grant, cmd_tag
  );
endinterface

// File: rtl/command_tag_credit_control.sv
// PSL command tag pool and command-credit sequencer: grants one tag per cycle
// when a tag and a credit are free, recycles tags from the response stream.
module command_tag_credit_control #(
  parameter int NUM_TAGS     = 32,
  parameter int TAG_WIDTH    = 8,
  parameter int CREDIT_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    rstn,
  input  logic                    enabled_in,
  input  logic [CREDIT_WIDTH-1:0] credits_init,
  command_tag_credit_control_if.slave bus,
  output logic [CREDIT_WIDTH-1:0] credits_avail,
  output logic [7:0]              tags_in_flight,
  output logic                    idle,
  output logic                    tag_error
);

  localparam int PW   = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam int CNTW = $clog2(NUM_TAGS + 1);
  localparam int SW   = CREDIT_WIDTH + 2;
  localparam logic [PW-1:0]          LAST_TAG  = PW'(NUM_TAGS - 1);
  localparam logic [TAG_WIDTH:0]     TAG_LIMIT = (TAG_WIDTH + 1)'(NUM_TAGS);
  localparam logic signed [SW-1:0]   CRED_MAX  = SW'((1 << CREDIT_WIDTH) - 1);

  localparam logic [1:0] ST_DISABLED = 2'd0;
  localparam logic [1:0] ST_INIT     = 2'd1;
  localparam logic [1:0] ST_ACTIVE   = 2'd2;
  localparam logic [1:0] ST_DRAIN    = 2'd3;

  logic [1:0]           state, state_nxt;
  logic [TAG_WIDTH-1:0] fifo_mem [NUM_TAGS];
  logic [PW-1:0]        rd_ptr, wr_ptr, init_cnt;
  logic [CNTW-1:0]      fifo_cnt;
  logic [NUM_TAGS-1:0]  alloc_map;

  logic [TAG_WIDTH-1:0] head_tag, push_data;
  logic [PW-1:0]        head_idx, resp_idx;
  logic                 resp_act, resp_legal, resp_bad, do_grant, push;
  logic [7:0]           tif_nxt;
  logic signed [SW-1:0] cred_cur, cred_dec, cred_ret, cred_sum;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_TAG) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [CREDIT_WIDTH-1:0] sat_credit(input logic signed [SW-1:0] v);
    if (v < 0)             return '0;
    else if (v > CRED_MAX) return '1;
    else                   return v[CREDIT_WIDTH-1:0];
  endfunction

  assign head_tag = fifo_mem[rd_ptr];
  assign head_idx = head_tag[PW-1:0];
  assign resp_idx = bus.resp_tag[PW-1:0];
  assign idle     = (state == ST_DISABLED);

  always_comb begin
    resp_act   = bus.resp_valid && (state != ST_DISABLED);
    resp_legal = resp_act && ({1'b0, bus.resp_tag} < TAG_LIMIT) && alloc_map[resp_idx];
    resp_bad   = resp_act && !resp_legal;
    // No bypass: a tag freed this cycle is only grantable from the next cycle.
    do_grant   = (state == ST_ACTIVE) && enabled_in && bus.cmd_req &&
                 (fifo_cnt != '0) && (credits_avail != '0);
    push       = (state == ST_INIT) || resp_legal;
    push_data  = (state == ST_INIT) ? TAG_WIDTH'(init_cnt) : bus.resp_tag;
    tif_nxt    = tags_in_flight + 8'(do_grant) - 8'(resp_legal);

    cred_cur = $signed({2'b00, credits_avail});
    cred_dec = do_grant ? SW'(1) : '0;
    cred_ret = resp_act ? SW'($signed(bus.resp_credits)) : '0;
    cred_sum = cred_cur - cred_dec + cred_ret;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_DISABLED: if (enabled_in) state_nxt = ST_INIT;
      ST_INIT: begin
        if (!enabled_in)                state_nxt = ST_DISABLED;
        else if (init_cnt == LAST_TAG)  state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: if (!enabled_in) state_nxt = (tags_in_flight != '0) ? ST_DRAIN : ST_DISABLED;
      ST_DRAIN:  if (tif_nxt == '0) state_nxt = ST_DISABLED;
      default:   state_nxt = ST_DISABLED;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state          <= ST_DISABLED;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      fifo_cnt       <= '0;
      init_cnt       <= '0;
      alloc_map      <= '0;
      credits_avail  <= '0;
      tags_in_flight <= '0;
      tag_error      <= 1'b0;
      bus.cmd_grant  <= 1'b0;
      bus.cmd_tag    <= '0;
    end else begin
      state          <= state_nxt;
      bus.cmd_grant  <= do_grant;
      bus.cmd_tag    <= do_grant ? head_tag : '0;
      tags_in_flight <= tif_nxt;
      init_cnt       <= (state == ST_INIT) ? ptr_inc(init_cnt) : '0;

      if (state == ST_DISABLED) begin
        if (enabled_in) begin
          credits_avail <= credits_init;
          tag_error     <= 1'b0;
        end
      end else begin
        credits_avail <= sat_credit(cred_sum);
        if (resp_bad) tag_error <= 1'b1;
      end

      if (do_grant)   alloc_map[head_idx] <= 1'b1;
      if (resp_legal) alloc_map[resp_idx] <= 1'b0;

      // Any return to DISABLED flushes the free list.
      if (state_nxt == ST_DISABLED) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (push)     wr_ptr <= ptr_inc(wr_ptr);
        if (do_grant) rd_ptr <= ptr_inc(rd_ptr);
        fifo_cnt <= fifo_cnt + CNTW'(push) - CNTW'(do_grant);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_command_tag_credit_control.sv
// Directed bench for command_tag_credit_control: vector table plus hand-written
// multi-cycle sequences for init, drain, empty pool and reset.
module tb_command_tag_credit_control;

  logic       clock = 1'b0;
  logic       rstn = 1'b0;
  logic       enabled_in = 1'b0;
  logic [7:0] credits_init = 8'd0;
  logic [7:0] credits_avail;
  logic [7:0] tags_in_flight;
  logic       idle;
  logic       tag_error;

  command_tag_credit_control_if #(.TAG_WIDTH(8)) bus();

  command_tag_credit_control #(
    .NUM_TAGS(32), .TAG_WIDTH(8), .CREDIT_WIDTH(8)
  ) dut (
    .clock          (clock),
    .rstn           (rstn),
    .enabled_in     (enabled_in),
    .credits_init   (credits_init),
    .bus            (bus),
    .credits_avail  (credits_avail),
    .tags_in_flight (tags_in_flight),
    .idle           (idle),
    .tag_error      (tag_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       req;
    logic       rv;
    logic [7:0] rtag;
    logic [8:0] rcred;
    logic       eg;
    logic [7:0] etag;
    int         ecred;
    int         etif;
  } vec_t;

  vec_t vt[14];
  int   total = 0;
  int   bad   = 0;
  int   exp_tags[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic req, input logic rv, input logic [7:0] rtag, input logic [8:0] rcred);
    bus.cmd_req      = req;
    bus.resp_valid   = rv;
    bus.resp_tag     = rtag;
    bus.resp_credits = rcred;
  endtask

  task automatic chk_out(input string nm, input int eg, input int etag, input int ecred, input int etif);
    chk({nm, ".grant"}, int'(bus.cmd_grant), eg);
    chk({nm, ".tag"},   int'(bus.cmd_tag), etag);
    chk({nm, ".cred"},  int'(credits_avail), ecred);
    chk({nm, ".tif"},   int'(tags_in_flight), etif);
  endtask

  task automatic chk_reset(input string nm);
    chk_out(nm, 0, 0, 0, 0);
    chk({nm, ".idle"}, int'(idle), 1);
    chk({nm, ".err"},  int'(tag_error), 0);
  endtask

  initial begin
    //            req rv  rtag   rcred    eg etag cred tif
    vt[0]  = '{1'b1, 1'b0, 8'd0, 9'd0,    1'b1, 8'd0, 2,   1};
    vt[1]  = '{1'b1, 1'b0, 8'd0, 9'd0,    1'b1, 8'd1, 1,   2};
    vt[2]  = '{1'b1, 1'b0, 8'd0, 9'd0,    1'b1, 8'd2, 0,   3};
    vt[3]  = '{1'b1, 1'b0, 8'd0, 9'd0,    1'b0, 8'd0, 0,   3};
    vt[4]  = '{1'b1, 1'b1, 8'd1, 9'd1,    1'b0, 8'd0, 1,   2};
    vt[5]  = '{1'b1, 1'b0, 8'd0, 9'd0,    1'b1, 8'd3, 0,   3};
    vt[6]  = '{1'b1, 1'b0, 8'd0, 9'd0,    1'b0, 8'd0, 0,   3};
    vt[7]  = '{1'b0, 1'b1, 8'd0, 9'd1,    1'b0, 8'd0, 1,   2};
    vt[8]  = '{1'b1, 1'b1, 8'd2, 9'd9,    1'b1, 8'd4, 9,   2};
    vt[9]  = '{1'b0, 1'b1, 8'd4, 9'h100,  1'b0, 8'd0, 0,   1};
    vt[10] = '{1'b0, 1'b1, 8'd3, 9'h0FF,  1'b0, 8'd0, 255, 0};
    vt[11] = '{1'b1, 1'b0, 8'd0, 9'd0,    1'b1, 8'd5, 254, 1};
    vt[12] = '{1'b1, 1'b1, 8'd5, 9'd1,    1'b1, 8'd6, 254, 1};
    vt[13] = '{1'b0, 1'b1, 8'd6, 9'h0FF,  1'b0, 8'd0, 255, 0};

    for (int i = 7; i < 32; i++) exp_tags.push_back(i);
    exp_tags.push_back(1); exp_tags.push_back(0); exp_tags.push_back(2);
    exp_tags.push_back(4); exp_tags.push_back(3); exp_tags.push_back(5);
    exp_tags.push_back(6);

    drive(1'b0, 1'b0, 8'd0, 9'd0);
    #12;
    chk_reset("reset");

    // Bring-up with 64 credits, request held through INIT.
    rstn = 1'b1;
    credits_init = 8'd64;
    enabled_in = 1'b1;
    drive(1'b1, 1'b0, 8'd0, 9'd0);
    tick();
    chk("enter_init.cred", int'(credits_avail), 64);
    chk("enter_init.idle", int'(idle), 0);
    for (int i = 0; i < 32; i++) begin
      tick();
      chk($sformatf("init%0d.grant", i), int'(bus.cmd_grant), 0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out($sformatf("b2b%0d", k), 1, k, 63 - k, k + 1);
    end
    drive(1'b0, 1'b0, 8'd0, 9'd0);
    tick();
    chk_out("req_drop", 0, 0, 60, 4);

    // Illegal response tags: unallocated, then out of range.
    drive(1'b0, 1'b1, 8'd5, 9'd0);
    tick();
    chk("bad5.err", int'(tag_error), 1);
    chk("bad5.tif", int'(tags_in_flight), 4);
    drive(1'b0, 1'b1, 8'd200, 9'd0);
    tick();
    chk("bad200.err", int'(tag_error), 1);
    chk("bad200.tif", int'(tags_in_flight), 4);
    drive(1'b0, 1'b0, 8'd0, 9'd0);
    tick();
    chk("sticky.err", int'(tag_error), 1);

    // Drain with four outstanding tags; re-enable during drain has no effect.
    enabled_in = 1'b0;
    drive(1'b1, 1'b0, 8'd0, 9'd0);
    tick();
    chk("drain.grant", int'(bus.cmd_grant), 0);
    chk("drain.idle", int'(idle), 0);
    enabled_in = 1'b1;
    credits_init = 8'd3;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 8'(i), 9'd1);
      tick();
      chk_out($sformatf("drain_resp%0d", i), 0, 0, 61 + i, 3 - i);
      chk($sformatf("drain_resp%0d.idle", i), int'(idle), (i == 3) ? 1 : 0);
    end
    drive(1'b0, 1'b0, 8'd0, 9'd0);
    tick();
    chk("reinit.err", int'(tag_error), 0);
    chk("reinit.cred", int'(credits_avail), 3);
    chk("reinit.idle", int'(idle), 0);
    repeat (32) tick();

    // Table: credit exhaustion, FIFO reuse order, same-cycle grant+response, clamping.
    for (int i = 0; i < 14; i++) begin
      drive(vt[i].req, vt[i].rv, vt[i].rtag, vt[i].rcred);
      tick();
      chk_out($sformatf("vec%0d", i), int'(vt[i].eg), int'(vt[i].etag), vt[i].ecred, vt[i].etif);
      chk($sformatf("vec%0d.err", i), int'(tag_error), 0);
    end

    // Exhaust the whole pool with ample credits.
    drive(1'b1, 1'b0, 8'd0, 9'd0);
    for (int k = 0; k < 32; k++) begin
      tick();
      chk_out($sformatf("pool%0d", k), 1, exp_tags[k], 254 - k, k + 1);
    end
    tick();
    chk_out("pool_empty", 0, 0, 223, 32);

    // Freed tag is not bypassed to a grant in the same cycle.
    drive(1'b1, 1'b1, 8'd7, 9'd0);
    tick();
    chk_out("nobypass", 0, 0, 223, 31);
    drive(1'b1, 1'b0, 8'd0, 9'd0);
    tick();
    chk_out("regrant7", 1, 7, 222, 32);

    drive(1'b0, 1'b1, 8'd8, 9'(-212));
    tick();
    chk_out("neg_cred", 0, 0, 10, 31);
    drive(1'b1, 1'b1, 8'd5, 9'd2);
    tick();
    chk_out("same_cycle", 1, 8, 11, 31);
    chk("same_cycle.err", int'(tag_error), 0);

    // Asynchronous reset in the middle of ACTIVE.
    rstn = 1'b0;
    #2;
    chk_reset("async_rst");
    drive(1'b0, 1'b0, 8'd0, 9'd0);
    tick();
    chk("held_rst.idle", int'(idle), 1);
    rstn = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/command_tag_credit_control.md
Name: command_tag_credit_control

Overview:
- Sequences PSL command issue for the AFU command path.
- Owns the pool of command tags and the PSL command-credit count.
- Grants one tag per cycle to the command arbiter when a tag and a credit are both free.
- Recycles tags and applies credit updates from the buffered PSL response stream that feeds response demultiplexing.

Parameters:
NUM_TAGS, 32, tag pool size; tags are 0..NUM_TAGS-1; legal range 2..255
TAG_WIDTH, 8, width of the PSL tag field
CREDIT_WIDTH, 8, width of the credit counter

Ports:
clock  in  1  clock
rstn  in  1  asynchronous active-low reset
enabled_in  in  1  AFU enable
credits_init  in  CREDIT_WIDTH  initial PSL command room (croom); sampled on entry to INIT
cmd_req  in  1  requester wants a tag this cycle
cmd_grant  out  1  registered; a tag is issued this cycle
cmd_tag  out  TAG_WIDTH  registered; tag issued; 0 when cmd_grant=0
resp_valid  in  1  PSL response valid
resp_tag  in  TAG_WIDTH  tag of the completed command
resp_credits  in  9  signed two's-complement credit return carried with the response
credits_avail  out  CREDIT_WIDTH  current credit count
tags_in_flight  out  8  number of allocated tags
idle  out  1  high in DISABLED
tag_error  out  1  sticky; response with an unallocated or out-of-range tag

Behaviour:
Reset values:
- State DISABLED.
- All outputs 0 except idle=1.
- Free-list FIFO empty; allocation bitmap clear.

States:
- DISABLED:
  - enabled_in=1 -> INIT.
  - On that edge, load the credit counter from credits_init and clear tag_error.
- INIT:
  - Pushes tags 0,1,..,NUM_TAGS-1 into the free list, one per cycle, so INIT lasts NUM_TAGS cycles.
  - After the last push -> ACTIVE.
  - cmd_req is ignored.
  - enabled_in=0 -> DISABLED next cycle; the free list is flushed.
- ACTIVE:
  - Grant and free as described below.
  - enabled_in=0 -> DRAIN if tags_in_flight>0, else DISABLED.
- DRAIN:
  - No grants; responses are still processed.
  - tags_in_flight reaches 0 -> DISABLED (free list flushed).
  - enabled_in re-asserting during DRAIN has no effect until DISABLED is reached.

Grant:
- Condition: cycle N has state=ACTIVE, enabled_in=1, cmd_req=1, free list not empty and credits_avail>0.
- At edge N+1: cmd_grant=1, cmd_tag=head of the free list (popped), credits_avail-1, tags_in_flight+1, bitmap bit set.
- Back-to-back grants every cycle are allowed while the condition holds.
- A requester that is not granted must re-request; no queueing.

Response (resp_valid=1, any state except DISABLED):
- Legal tag (tag<NUM_TAGS and bitmap bit set): push the tag to the free-list tail, clear the bitmap bit, tags_in_flight-1.
- Illegal tag: no push, tags_in_flight unchanged, tag_error<=1 (sticky).
- credits_avail += sign-extended resp_credits in both cases.
- In DISABLED, resp_valid is ignored.

Simultaneous grant and response, same cycle:
- Both apply.
- Credit result = credits - 1 + resp_credits.
- tags_in_flight unchanged.
- The free list pops and pushes in the same edge.
- No bypass: if the free list is empty at cycle N, no grant is made even if a response frees a tag at N.
- A response freeing the same tag being granted is impossible, since that tag is not allocated; it is flagged as tag_error.

Arithmetic:
- Credit update computed at CREDIT_WIDTH+2 bits, then clamped to [0, 2^CREDIT_WIDTH-1].
- Free list is a circular FIFO of NUM_TAGS entries; pointers wrap modulo NUM_TAGS.
- The FIFO can never overflow, because the bitmap guarantees at most NUM_TAGS legal frees.

Reset mid-operation: asynchronous return to the reset values; outstanding tags are forgotten.

Test Plan:
1. Reset, credits_init=64, enabled_in=1 -> 32 INIT cycles, then ACTIVE; cmd_req held -> cmd_grant every cycle with tags 0,1,2,..; credits_avail 63,62,..
2. credits_init=3, cmd_req held -> exactly 3 grants (tags 0,1,2) then cmd_grant=0; response tag 1, resp_credits=+1 -> next grant returns tag 3 (FIFO order), credits_avail back to 0 after it.
3. All 32 tags granted, credits ample -> no grant while empty; response tag 7 at cycle N with cmd_req -> no grant at N+1, grant tag 7 at N+2.
4. Same-cycle grant and response (tag 5, resp_credits=+2, credits=10) -> credits_avail=11, tags_in_flight unchanged.
5. Response with tag 5 never allocated, then tag 200 -> tag_error=1 and stays 1, tags_in_flight unchanged; cleared on the next DISABLED->INIT.
6. 4 tags outstanding, enabled_in=0 -> DRAIN, no grants; 4 responses -> DISABLED, idle=1; rstn pulsed mid-ACTIVE -> all outputs at their reset values immediately.
